// File: rtl/kavach_threat_escalator.sv
// Security threat escalator: counts severity events in a sliding window and escalates
// MONITOR -> SUSPECT -> ALERT -> LOCKDOWN, with a keyed software exit from LOCKDOWN.
module kavach_threat_escalator #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SUSPECT_LIMIT = 3,
  parameter int unsigned LOCK_CYCLES   = 64,
  parameter logic [7:0]  UNLOCK_KEY    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       monitor_ready,
  input  logic       temp_hi_anomaly,
  input  logic       temp_lo_anomaly,
  input  logic       temp_roc_alert,
  input  logic       temp_sustained,
  input  logic [1:0] severity,
  input  logic       sw_ack,
  input  logic       sw_clr_lock,
  input  logic [7:0] sw_clr_key,
  output logic [2:0] esc_state,
  output logic       irq,
  output logic       lockdown,
  output logic       zeroize_req,
  output logic       key_fail,
  output logic [3:0] cause_latch,
  output logic [7:0] event_cnt
);

  localparam int unsigned TW = $clog2(WINDOW_CYCLES);
  localparam int unsigned HW = $clog2(LOCK_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LOCK_CYCLES - 1);
  localparam logic [7:0]    LIMIT      = 8'(SUSPECT_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MONITOR  = 3'd1,
    ST_SUSPECT  = 3'd2,
    ST_ALERT    = 3'd3,
    ST_LOCKDOWN = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sev_prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    cause_q, cause_d;
  logic          irq_q, irq_d;
  logic          lockdown_q, lockdown_d;
  logic          zeroize_q, zeroize_d;
  logic          key_fail_q, key_fail_d;

  logic       ev;
  logic       sev_high;
  logic       sev_none;
  logic [7:0] cnt_inc;
  logic [3:0] flags;
  logic       key_match;

  // An event is the rising edge of "any severity" against the registered copy.
  assign ev        = (severity != 2'b00) && (sev_prev_q == 2'b00);
  assign sev_high  = (severity == 2'b11);
  assign sev_none  = (severity == 2'b00);
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign flags     = {temp_sustained, temp_roc_alert, temp_lo_anomaly, temp_hi_anomaly};
  assign key_match = (sw_clr_key == UNLOCK_KEY);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    key_fail_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        hold_d  = '0;
        cnt_d   = '0;
        if (monitor_ready) state_d = ST_MONITOR;
      end

      ST_MONITOR: begin
        timer_d = '0;
        hold_d  = '0;
        if (!monitor_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sev_high) begin
          state_d = ST_ALERT;
          cnt_d   = ev ? 8'd1 : 8'd0;
        end else if (ev) begin
          state_d = (SUSPECT_LIMIT <= 1) ? ST_ALERT : ST_SUSPECT;
          cnt_d   = 8'd1;
        end
      end

      ST_SUSPECT: begin
        cause_d = cause_q | flags;
        timer_d = timer_q + TW'(1);
        if (ev) cnt_d = cnt_inc;
        if (!monitor_ready) begin
          state_d = ST_IDLE;
          timer_d = '0;
          cnt_d   = '0;
        end else if ((ev && cnt_inc >= LIMIT) || sev_high) begin
          state_d = ST_ALERT;
          timer_d = '0;
          hold_d  = '0;
        end else if (timer_q == TIMER_LAST) begin
          // Expiry: an event on this very cycle opens a fresh window instead of retiring.
          timer_d = '0;
          if (ev) begin
            cnt_d = 8'd1;
          end else begin
            state_d = ST_MONITOR;
            cnt_d   = '0;
          end
        end
      end

      ST_ALERT: begin
        cause_d = cause_q | flags;
        if (ev) cnt_d = cnt_inc;
        hold_d = sev_high ? hold_q + HW'(1) : '0;
        if (sev_high && hold_q == HOLD_LAST) begin
          state_d = ST_LOCKDOWN;
          hold_d  = '0;
        end else if (sw_ack && sev_none) begin
          state_d = ST_MONITOR;
          hold_d  = '0;
          cnt_d   = '0;
          cause_d = '0;
        end
      end

      ST_LOCKDOWN: begin
        cause_d = cause_q | flags;
        if (sw_clr_lock) begin
          if (!key_match) begin
            key_fail_d = 1'b1;
          end else if (sev_none) begin
            state_d = ST_MONITOR;
            timer_d = '0;
            hold_d  = '0;
            cnt_d   = '0;
            cause_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        hold_d  = '0;
        cnt_d   = '0;
      end
    endcase

    irq_d      = (state_d == ST_ALERT) || (state_d == ST_LOCKDOWN);
    lockdown_d = (state_d == ST_LOCKDOWN);
    zeroize_d  = (state_d == ST_LOCKDOWN) && (state_q != ST_LOCKDOWN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sev_prev_q <= 2'b00;
      timer_q    <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      cause_q    <= '0;
      irq_q      <= 1'b0;
      lockdown_q <= 1'b0;
      zeroize_q  <= 1'b0;
      key_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sev_prev_q <= severity;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      irq_q      <= irq_d;
      lockdown_q <= lockdown_d;
      zeroize_q  <= zeroize_d;
      key_fail_q <= key_fail_d;
    end
  end

  assign esc_state   = state_q;
  assign irq         = irq_q;
  assign lockdown    = lockdown_q;
  assign zeroize_req = zeroize_q;
  assign key_fail    = key_fail_q;
  assign cause_latch = cause_q;
  assign event_cnt   = cnt_q;

endmodule
